// File: rtl/bru_pkg.sv
// ============================================================================
// bru_pkg : funct3 codes and stage payload types for the branch resolve unit
// Rev 1.0
// ============================================================================
`default_nettype none

package bru_pkg;

    // Data fields are sized for the widest supported XLEN; narrower builds
    // zero-extend into them and use only the low XLEN bits.
    localparam int XLEN_MAX = 64;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef struct packed {
        logic                is_branch;
        logic [2:0]          funct3;
        logic [XLEN_MAX-1:0] rs1;
        logic [XLEN_MAX-1:0] rs2;
        logic [XLEN_MAX-1:0] pc;
        logic [XLEN_MAX-1:0] imm;
        logic                pred_taken;
    } bru_s1_t;

    typedef struct packed {
        logic                is_branch;
        logic                taken;
        logic                mispredict;
        logic                illegal;
        logic [XLEN_MAX-1:0] next_pc;
    } bru_s2_t;

endpackage

`default_nettype wire

// File: rtl/bru_compare.sv
// ============================================================================
// bru_compare : combinational funct3 condition evaluator
// Rev 1.0
// ============================================================================
`default_nettype none

module bru_compare
    import bru_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            taken_o,
    output logic            illegal_o
);

    logic eq;
    logic lt_s;
    logic lt_u;

    assign eq   = (rs1_i == rs2_i);
    assign lt_s = ($signed(rs1_i) < $signed(rs2_i));
    assign lt_u = (rs1_i < rs2_i);

    always_comb begin
        taken_o   = 1'b0;
        illegal_o = 1'b0;
        case (funct3_i)
            F3_BEQ:  taken_o = eq;
            F3_BNE:  taken_o = !eq;
            F3_BLT:  taken_o = lt_s;
            F3_BGE:  taken_o = !lt_s;
            F3_BLTU: taken_o = lt_u;
            F3_BGEU: taken_o = !lt_u;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/branch_resolve_unit.sv
// ============================================================================
// branch_resolve_unit : two-stage branch resolution with valid/ready handshake
// Optional perf counters under BRU_PERF_CNT_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int ILEN_BYTES = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic            in_is_branch_i,
    input  logic [2:0]      in_funct3_i,
    input  logic [XLEN-1:0] in_rs1_i,
    input  logic [XLEN-1:0] in_rs2_i,
    input  logic [XLEN-1:0] in_pc_i,
    input  logic [XLEN-1:0] in_imm_i,
    input  logic            in_pred_taken_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic            out_taken_o,
    output logic            out_mispredict_o,
    output logic            out_illegal_o,
    output logic [XLEN-1:0] out_next_pc_o
`ifdef BRU_PERF_CNT_EN
    ,
    output logic [31:0]     perf_branches_o,
    output logic [31:0]     perf_mispredicts_o
`endif
);

    logic            s1_valid_q;
    logic            s2_valid_q;
    bru_s1_t         s1_q;
    bru_s1_t         s1_d;
    bru_s2_t         s2_q;
    bru_s2_t         s2_d;
    logic            s1_adv;
    logic            s2_adv;
    logic            cmp_taken;
    logic            cmp_illegal;
    logic            taken;
    logic [XLEN-1:0] target_pc;
    logic [XLEN-1:0] fallthrough_pc;

    assign s2_adv     = !s2_valid_q || out_ready_i;
    assign s1_adv     = !s1_valid_q || s2_adv;
    assign in_ready_o = s1_adv && !flush_i && !rst;

    always_comb begin
        s1_d            = '0;
        s1_d.is_branch  = in_is_branch_i;
        s1_d.funct3     = in_funct3_i;
        s1_d.rs1        = XLEN_MAX'(in_rs1_i);
        s1_d.rs2        = XLEN_MAX'(in_rs2_i);
        s1_d.pc         = XLEN_MAX'(in_pc_i);
        s1_d.imm        = XLEN_MAX'(in_imm_i);
        s1_d.pred_taken = in_pred_taken_i;
    end

    bru_compare #(
        .XLEN (XLEN)
    ) u_compare (
        .funct3_i  (s1_q.funct3),
        .rs1_i     (s1_q.rs1[XLEN-1:0]),
        .rs2_i     (s1_q.rs2[XLEN-1:0]),
        .taken_o   (cmp_taken),
        .illegal_o (cmp_illegal)
    );

    assign taken          = s1_q.is_branch && cmp_taken;
    assign target_pc      = s1_q.pc[XLEN-1:0] + s1_q.imm[XLEN-1:0];
    assign fallthrough_pc = s1_q.pc[XLEN-1:0] + XLEN'(ILEN_BYTES);

    // An empty S1 loads zeros so the outputs read exactly 0 whenever invalid.
    always_comb begin
        s2_d = '0;
        if (s1_valid_q) begin
            s2_d.is_branch  = s1_q.is_branch;
            s2_d.taken      = taken;
            s2_d.mispredict = taken ^ s1_q.pred_taken;
            s2_d.illegal    = s1_q.is_branch && cmp_illegal;
            s2_d.next_pc    = XLEN_MAX'(taken ? target_pc : fallthrough_pc);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_q       <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= in_valid_i;
                s1_q       <= s1_d;
            end
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
                s2_q       <= s2_d;
            end
        end
    end

    assign out_valid_o      = s2_valid_q;
    assign out_taken_o      = s2_q.taken;
    assign out_mispredict_o = s2_q.mispredict;
    assign out_illegal_o    = s2_q.illegal;
    assign out_next_pc_o    = s2_q.next_pc[XLEN-1:0];

`ifdef BRU_PERF_CNT_EN
    logic [31:0] perf_br_q;
    logic [31:0] perf_mis_q;
    logic        xfer;

    // A transfer coinciding with flush is discarded by the consumer, so it is not counted.
    assign xfer = s2_valid_q && out_ready_i && !flush_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_br_q  <= '0;
            perf_mis_q <= '0;
        end else if (xfer && s2_q.is_branch) begin
            if (perf_br_q != 32'hFFFF_FFFF) begin
                perf_br_q <= perf_br_q + 32'd1;
            end
            if (s2_q.mispredict && (perf_mis_q != 32'hFFFF_FFFF)) begin
                perf_mis_q <= perf_mis_q + 32'd1;
            end
        end
    end

    assign perf_branches_o    = perf_br_q;
    assign perf_mispredicts_o = perf_mis_q;
`else
    logic unused_is_branch;
    assign unused_is_branch = s2_q.is_branch;
`endif

    generate
        if (XLEN < XLEN_MAX) begin : g_pad_sink
            logic unused_pad;
            assign unused_pad = ^{s1_q.rs1[XLEN_MAX-1:XLEN], s1_q.rs2[XLEN_MAX-1:XLEN],
                                  s1_q.pc[XLEN_MAX-1:XLEN], s1_q.imm[XLEN_MAX-1:XLEN],
                                  s2_q.next_pc[XLEN_MAX-1:XLEN]};
        end
    endgenerate

endmodule

`default_nettype wire
